// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back select, 32-entry register file and retire counter.
// Two combinational read ports with same-cycle write bypass; $0 reads as zero.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] ReadData,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [31:0]       WriteRegister,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] WriteData_Out,
    output logic [31:0]       RetireCount
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [ADDR_W-1:0] wa;
    logic              retire;
    logic              commit;
    logic              unused_wr_hi;

    assign WriteData_Out = MemtoReg ? ReadData : ALUResult;
    assign wa            = WriteRegister[ADDR_W-1:0];
    assign unused_wr_hi  = ^WriteRegister[31:ADDR_W];
    assign retire        = !reset && enable && RegWrite;
    assign commit        = retire && (wa != '0);

    // Array update: clear on reset, otherwise commit one entry (never $0).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wa] <= WriteData_Out;
        end
    end

    // Retired-write counter; writes aimed at $0 still count, wraps silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            RetireCount <= '0;
        end else if (retire) begin
            RetireCount <= RetireCount + 32'd1;
        end
    end

    // Read port 1: zero register, then bypass, then array.
    always_comb begin
        ReadData1 = regs[ReadRegister1];
        if (ReadRegister1 == '0) begin
            ReadData1 = '0;
        end else if (commit && (ReadRegister1 == wa)) begin
            ReadData1 = WriteData_Out;
        end
    end

    // Read port 2: same resolution order as port 1.
    always_comb begin
        ReadData2 = regs[ReadRegister2];
        if (ReadRegister2 == '0) begin
            ReadData2 = '0;
        end else if (commit && (ReadRegister2 == wa)) begin
            ReadData2 = WriteData_Out;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vector table plus hand-written reset, fill and
// mid-stream reset sequences for wb_regfile.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        MemtoReg;
    logic        RegWrite;
    logic [31:0] ReadData;
    logic [31:0] ALUResult;
    logic [31:0] WriteRegister;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] WriteData_Out;
    logic [31:0] RetireCount;

    int n_chk;
    int n_fail;

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .ReadData     (ReadData),
        .ALUResult    (ALUResult),
        .WriteRegister(WriteRegister),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2),
        .WriteData_Out(WriteData_Out),
        .RetireCount  (RetireCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        m2r;
        logic        rw;
        logic [31:0] rdat;
        logic [31:0] alu;
        logic [31:0] wreg;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ew;
        logic [31:0] ec;
    } vec_t;

    vec_t tv[14];

    function automatic vec_t mk(
        input logic        rst, en, m2r, rw,
        input logic [31:0] rdat, alu, wreg,
        input logic [4:0]  rr1, rr2,
        input logic [31:0] e1, e2, ew, ec
    );
        vec_t v;
        v.rst = rst; v.en = en; v.m2r = m2r; v.rw = rw;
        v.rdat = rdat; v.alu = alu; v.wreg = wreg;
        v.rr1 = rr1; v.rr2 = rr2;
        v.e1 = e1; v.e2 = e2; v.ew = ew; v.ec = ec;
        return v;
    endfunction

    task automatic drive(
        input logic        rst, en, m2r, rw,
        input logic [31:0] rdat, alu, wreg,
        input logic [4:0]  rr1, rr2
    );
        reset = rst; enable = en; MemtoReg = m2r; RegWrite = rw;
        ReadData = rdat; ALUResult = alu; WriteRegister = wreg;
        ReadRegister1 = rr1; ReadRegister2 = rr2;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Combinational sweep of both ports with the write side idle.
    task automatic sweep(input string tag, input logic zero_all);
        logic [31:0] e;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            e = (zero_all || i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
            chk($sformatf("%s rd1 r%0d", tag, i), ReadData1, e);
            e = (zero_all || i == 31) ? 32'h0 : 32'h1000_0000 + 32'(31 - i);
            chk($sformatf("%s rd2 r%0d", tag, 31 - i), ReadData2, e);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;

        // rst en m2r rw rdat alu wreg rr1 rr2 | e1 e2 ew cnt
        tv[0]  = mk(0,1,0,1, 32'h0, 32'h1234_5678, 32'd5, 5, 0,
                    32'h1234_5678, 32'h0, 32'h1234_5678, 32'd0);
        tv[1]  = mk(0,1,0,0, 32'h0, 32'h0, 32'd0, 5, 5,
                    32'h1234_5678, 32'h1234_5678, 32'h0, 32'd1);
        tv[2]  = mk(0,1,1,1, 32'hDEAD_BEEF, 32'h1111_1111, 32'd9, 9, 9,
                    32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd1);
        tv[3]  = mk(0,1,0,0, 32'h0, 32'h0, 32'd0, 9, 5,
                    32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'd2);
        tv[4]  = mk(0,1,0,1, 32'h0, 32'hFFFF_FFFF, 32'd0, 0, 0,
                    32'h0, 32'h0, 32'hFFFF_FFFF, 32'd2);
        tv[5]  = mk(0,1,0,1, 32'h0, 32'hFFFF_FFFF, 32'h20, 0, 5,
                    32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 32'd3);
        tv[6]  = mk(0,1,0,0, 32'h0, 32'h0, 32'd0, 0, 9,
                    32'h0, 32'hDEAD_BEEF, 32'h0, 32'd4);
        tv[7]  = mk(0,1,0,1, 32'h0, 32'h77, 32'd7, 7, 0,
                    32'h77, 32'h0, 32'h77, 32'd4);
        tv[8]  = mk(0,0,0,1, 32'h0, 32'hA5A5_A5A5, 32'd7, 7, 7,
                    32'h77, 32'h77, 32'hA5A5_A5A5, 32'd5);
        tv[9]  = mk(0,0,0,1, 32'h0, 32'hA5A5_A5A5, 32'd7, 7, 7,
                    32'h77, 32'h77, 32'hA5A5_A5A5, 32'd5);
        tv[10] = mk(0,1,0,1, 32'h0, 32'hA5A5_A5A5, 32'd7, 7, 7,
                    32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd5);
        tv[11] = mk(0,1,0,0, 32'h0, 32'h0, 32'd0, 7, 9,
                    32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'h0, 32'd6);
        tv[12] = mk(0,1,0,1, 32'h0, 32'h33, 32'hFFFF_FFE3, 3, 7,
                    32'h33, 32'hA5A5_A5A5, 32'h33, 32'd6);
        tv[13] = mk(0,1,0,0, 32'h0, 32'h0, 32'd0, 3, 7,
                    32'h33, 32'hA5A5_A5A5, 32'h0, 32'd7);

        // Power-on reset, one cycle, then sweep with the write side idle.
        drive(1,0,0,0, 32'h0, 32'h0, 32'd0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0,0,0,0, 32'h0, 32'h0, 32'd0, 0, 0);
        #1;
        chk("reset count", RetireCount, 32'd0);
        sweep("reset", 1'b1);

        // Directed vector table: outputs checked before each edge.
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            drive(tv[k].rst, tv[k].en, tv[k].m2r, tv[k].rw, tv[k].rdat,
                  tv[k].alu, tv[k].wreg, tv[k].rr1, tv[k].rr2);
            #2;
            chk($sformatf("v%0d rd1", k), ReadData1, tv[k].e1);
            chk($sformatf("v%0d rd2", k), ReadData2, tv[k].e2);
            chk($sformatf("v%0d wdo", k), WriteData_Out, tv[k].ew);
            chk($sformatf("v%0d cnt", k), RetireCount, tv[k].ec);
        end

        // Fill r1..r31 with distinct values.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(0,1,0,1, 32'h0, 32'h1000_0000 + 32'(i), 32'(i), 0, 0);
        end
        @(negedge clk);
        drive(0,0,0,0, 32'h0, 32'h0, 32'd0, 0, 0);
        #1;
        chk("fill count", RetireCount, 32'd38);
        sweep("fill", 1'b0);

        // Reset in the same cycle as a write to r3: bypass suppressed.
        @(negedge clk);
        drive(1,1,0,1, 32'h0, 32'h0000_0BAD, 32'd3, 3, 4);
        #2;
        chk("rstwr rd1", ReadData1, 32'h1000_0003);
        chk("rstwr rd2", ReadData2, 32'h1000_0004);
        chk("rstwr wdo", WriteData_Out, 32'h0000_0BAD);

        // Reset held a second cycle: array already clear, still no bypass.
        @(negedge clk);
        drive(1,1,1,1, 32'h0000_0C0D, 32'h0, 32'd3, 3, 3);
        #2;
        chk("rsthold rd1", ReadData1, 32'h0);
        chk("rsthold wdo", WriteData_Out, 32'h0000_0C0D);
        chk("rsthold cnt", RetireCount, 32'd0);

        @(negedge clk);
        drive(0,0,0,0, 32'h0, 32'h0, 32'd0, 0, 0);
        #1;
        chk("postrst count", RetireCount, 32'd0);
        sweep("postrst", 1'b1);

        // First commit after reset deasserts.
        @(negedge clk);
        drive(0,1,0,1, 32'h0, 32'h55, 32'd3, 3, 0);
        #2;
        chk("first rd1", ReadData1, 32'h55);
        @(negedge clk);
        drive(0,1,0,0, 32'h0, 32'h0, 32'd0, 3, 3);
        #2;
        chk("first arr", ReadData2, 32'h55);
        chk("first cnt", RetireCount, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the MIPS core, the consumer end of the MEM/WB pipeline register. Each cycle it selects the write-back value (memory load data or ALU result), commits it to a 32 x 32-bit register file, and serves the two ID-stage read ports. Same-cycle write-to-read bypass lets ID see the value being written. A retired-write counter supports debug and performance checks.

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width; the file has 2^ADDR_W entries

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  stage enable; 0 = stall, no commit, no count
- MemtoReg  in  1  1 = write ReadData, 0 = write ALUResult
- RegWrite  in  1  write request for this cycle
- ReadData  in  DATA_W  load data from the MEM/WB register
- ALUResult  in  DATA_W  ALU result from the MEM/WB register
- WriteRegister  in  32  destination register; only bits [ADDR_W-1:0] are used, upper bits ignored
- ReadRegister1  in  ADDR_W  read port 1 address
- ReadRegister2  in  ADDR_W  read port 2 address
- ReadData1  out  DATA_W  read port 1 data, combinational
- ReadData2  out  DATA_W  read port 2 data, combinational
- WriteData_Out  out  DATA_W  selected write-back value, combinational, for the forwarding unit
- RetireCount  out  32  count of committed RegWrite cycles, registered

## Operation
- WriteData_Out = MemtoReg ? ReadData : ALUResult. It is driven every cycle, regardless of RegWrite or enable.
- Define wa = WriteRegister[ADDR_W-1:0].
- Define commit = !reset & enable & RegWrite & (wa != 0).
- On a rising edge with commit=1, reg[wa] <= WriteData_Out. No other entry changes.
- Register 0 is hardwired to zero. A read of address 0 returns 0. A write to address 0 is discarded.
- Read port n (n = 1, 2) resolves in this priority:
  - ReadRegistern == 0 -> 0.
  - Else commit && ReadRegistern == wa -> WriteData_Out (bypass).
  - Else -> reg[ReadRegistern].
- Both ports may read the same address. Both may hit the bypass in the same cycle.
- RetireCount increments by 1 on each rising edge where !reset & enable & RegWrite. Writes targeting $0 are counted.
- RetireCount wraps from 0xFFFFFFFF to 0 with no flag.
- Reset: on a rising edge with reset=1:
  - All register entries are cleared to 0.
  - RetireCount is cleared to 0.
  - Reset overrides enable and RegWrite. A write requested in the reset cycle is lost.
- Reset values: ReadData1 and ReadData2 are 0 after reset for any address. WriteData_Out follows its inputs, including during reset.
- X-safety: a RegWrite that is X while enable=1 is a bench error. The RTL does not need to mask it.

## Timing
- Write latency: the value is in the array after 1 rising edge. It is visible on the read ports in the same cycle through the bypass, then from the array from the next cycle onward.
- Read latency: 0 cycles, combinational from ReadRegistern and the write-side inputs.
- Stall (enable=0): the array and RetireCount hold. The bypass is inactive because commit=0, so reads return the array contents.
- Reset asserted mid-stream:
  - The clear takes effect at the first rising edge where reset=1.
  - While reset=1 the bypass is suppressed, so reads return the array contents, which are all 0 from that first edge onward.
  - The first commit is possible on the edge after reset deasserts.
- There is no handshake. The upstream MEM/WB register presents a new write request each enabled cycle.

## Test plan
- Reset: hold reset=1 for 1 cycle, sweep ReadRegister1 and ReadRegister2 over 0..31 -> all reads return 0 and RetireCount=0.
- ALU write-back: RegWrite=1, MemtoReg=0, ALUResult=0x1234_5678, WriteRegister=5, enable=1 for one edge, then read r5 -> ReadData1=0x1234_5678 and RetireCount=1.
- Load write-back with bypass: MemtoReg=1, ReadData=0xDEAD_BEEF, WriteRegister=9, ReadRegister1=ReadRegister2=9 in the same cycle -> both ports return 0xDEAD_BEEF before the edge, and the array holds it after the edge.
- $zero protection: write 0xFFFF_FFFF to WriteRegister=0 (and 0x20, whose low bits are 0) -> a read of r0 returns 0 with no bypass, and RetireCount increments by 2.
- Stall: enable=0, RegWrite=1, WriteRegister=7, ALUResult=0xA5A5_A5A5 -> r7 keeps its old value, no bypass occurs, and RetireCount is unchanged. Set enable=1 -> the write commits.
- Reset mid-operation: fill r1..r31 with distinct values, then assert reset in the same cycle as a write to r3 -> all entries read 0 afterwards, the r3 write is lost, and RetireCount=0.
